// File: rtl/prog_loader.sv
// prog_loader: streams a program (count, bytes, checksum) into CPU
// instruction memory and holds the CPU in reset until a good load.
// Ports:
//   clk, reset (sync, active-high), start (begin a load)
//   in_valid/in_data/in_ready : upstream byte stream handshake
//   ext_mem_write/ext_write_data/ext_data_adr : imem write port
//   cpu_reset : held high except after a successful load
//   busy/done/error : load status; loaded_count : bytes written
module prog_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ext_mem_write,
  output logic [7:0] ext_write_data,
  output logic [7:0] ext_data_adr,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] loaded_count
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, CSUM, DONE, ERR
  } state_t;

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] idleLast = IW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [7:0]    hdrN;
  logic [7:0]    wrCnt;
  logic [7:0]    sum;
  logic [IW-1:0] idleCnt;
  logic          loading;
  logic          accept;

  assign loading = (state == HDR) || (state == DATA) || (state == CSUM);
  assign accept  = in_valid && loading;

  assign in_ready     = loading;
  assign busy         = loading;
  assign done         = (state == DONE);
  assign error        = (state == ERR);
  assign cpu_reset    = (state != DONE);
  assign loaded_count = wrCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      hdrN           <= '0;
      wrCnt          <= '0;
      sum            <= '0;
      idleCnt        <= '0;
      ext_mem_write  <= 1'b0;
      ext_write_data <= '0;
      ext_data_adr   <= '0;
    end else begin
      // Strobe is a single-cycle pulse following each data accept.
      ext_mem_write <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state   <= HDR;
            wrCnt   <= '0;
            sum     <= '0;
            idleCnt <= '0;
          end
        end
        HDR: begin
          if (accept) begin
            hdrN  <= in_data;
            state <= (in_data == 8'd0) ? CSUM : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            ext_mem_write  <= 1'b1;
            ext_write_data <= in_data;
            ext_data_adr   <= wrCnt;
            wrCnt          <= wrCnt + 8'd1;
            sum            <= sum + in_data;
            if (wrCnt == hdrN - 8'd1) state <= CSUM;
          end
        end
        CSUM: begin
          if (accept) state <= (in_data == sum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
      // Idle watchdog; overrides nothing since no accept means
      // no transition was taken above.
      if (loading) begin
        if (accept) begin
          idleCnt <= '0;
        end else if (idleCnt == idleLast) begin
          idleCnt <= '0;
          state   <= ERR;
        end else begin
          idleCnt <= idleCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed streams against a byte-level load model,
// compared every cycle, plus literal expectations per scenario.
module tb_prog_loader;

  localparam int TO = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       ext_mem_write;
  logic [7:0] ext_write_data;
  logic [7:0] ext_data_adr;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] loaded_count;

  prog_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ext_mem_write(ext_mem_write), .ext_write_data(ext_write_data),
    .ext_data_adr(ext_data_adr), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error),
    .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Byte-level model of a load: counts accepted bytes against N.
  bit         mOn = 0;
  bit         mActive, mHaveHdr, mWr;
  int         mN, mGot, mIdle, mResult;
  logic [7:0] mSum, mData, mAdr;

  task automatic modelStep();
    mWr = 0;
    if (reset) begin
      mActive = 0; mResult = 0; mGot = 0; mSum = 0;
      mIdle = 0; mData = 0; mAdr = 0; mOn = 1;
    end else if (!mActive) begin
      if (start) begin
        mActive = 1; mHaveHdr = 0; mGot = 0;
        mSum = 0; mIdle = 0; mResult = 0;
      end
    end else if (in_valid) begin
      mIdle = 0;
      if (!mHaveHdr) begin
        mN = int'(in_data); mHaveHdr = 1;
      end else if (mGot < mN) begin
        mWr = 1; mData = in_data; mAdr = 8'(mGot);
        mGot++; mSum = mSum + in_data;
      end else begin
        mActive = 0;
        mResult = (in_data == mSum) ? 1 : 2;
      end
    end else begin
      mIdle++;
      if (mIdle == TO) begin
        mActive = 0; mResult = 2;
      end
    end
  endtask

  logic [15:0] wrLog[$];
  logic [15:0] want[$];
  logic [15:0] saved[$];

  always @(negedge clk) begin
    if (mOn) begin
      logic eDone, eErr;
      eDone = !mActive && mResult == 1;
      eErr  = !mActive && mResult == 2;
      chk("in_ready", 16'(in_ready), 16'(mActive));
      chk("busy", 16'(busy), 16'(mActive));
      chk("done", 16'(done), 16'(eDone));
      chk("error", 16'(error), 16'(eErr));
      chk("cpu_reset", 16'(cpu_reset), 16'(!eDone));
      chk("ext_mem_write", 16'(ext_mem_write), 16'(mWr));
      chk("ext_write_data", 16'(ext_write_data), 16'(mData));
      chk("ext_data_adr", 16'(ext_data_adr), 16'(mAdr));
      chk("loaded_count", 16'(loaded_count), 16'(mGot));
      if (ext_mem_write === 1'b1)
        wrLog.push_back({ext_data_adr, ext_write_data});
    end
  end

  task automatic tick(input logic s, input logic v,
                      input logic [7:0] d, input logic r);
    start = s; in_valid = v; in_data = d; reset = r;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic load(input logic [7:0] b[$], input bit gaps);
    tick(1, 0, 8'h00, 0);
    foreach (b[i]) begin
      tick(0, 1, b[i], 0);
      if (gaps && i + 1 < b.size()) tick(i == 2, 0, 8'hEE, 0);
    end
  endtask

  task automatic checkWrites(input string nm);
    chk({nm, "_count"}, 16'(wrLog.size()), 16'(want.size()));
    for (int i = 0; i < want.size() && i < wrLog.size(); i++)
      chk({nm, "_entry"}, wrLog[i], want[i]);
  endtask

  task automatic pins(input string nm, input logic d, input logic e,
                      input logic c, input logic [7:0] n);
    chk({nm, "_done"}, 16'(done), 16'(d));
    chk({nm, "_error"}, 16'(error), 16'(e));
    chk({nm, "_cpu_reset"}, 16'(cpu_reset), 16'(c));
    chk({nm, "_loaded"}, 16'(loaded_count), 16'(n));
  endtask

  initial begin
    logic [7:0] s[$];
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    pins("rst", 0, 0, 1, 8'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_wdata", 16'(ext_write_data), 16'd0);

    wrLog.delete();
    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    load(s, 0);
    tick(0, 0, 0, 0);
    want = '{16'h0011, 16'h0122, 16'h0233};
    checkWrites("good3");
    pins("good3", 1, 0, 0, 8'd3);

    wrLog.delete();
    s = '{8'h02, 8'h10, 8'h20, 8'h31};
    load(s, 0);
    tick(0, 0, 0, 0);
    want = '{16'h0010, 16'h0120};
    checkWrites("badsum");
    pins("badsum", 0, 1, 1, 8'd2);

    wrLog.delete();
    s = '{8'h00, 8'h00};
    load(s, 0);
    tick(0, 0, 0, 0);
    want = {};
    checkWrites("empty");
    pins("empty", 1, 0, 0, 8'd0);
    s = '{8'h00, 8'h01};
    load(s, 0);
    pins("emptybad", 0, 1, 1, 8'd0);

    wrLog.delete();
    s = '{8'h02, 8'hAA};
    load(s, 0);
    repeat (TO - 1) tick(0, 0, 0, 0);
    chk("to_early_busy", 16'(busy), 16'd1);
    repeat (2) tick(0, 0, 0, 0);
    want = '{16'h00AA};
    checkWrites("timeout");
    pins("timeout", 0, 1, 1, 8'd1);

    wrLog.delete();
    s = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    load(s, 0);
    tick(0, 0, 0, 0);
    saved = wrLog;
    pins("nogap", 1, 0, 0, 8'd4);
    wrLog.delete();
    load(s, 1);
    tick(0, 0, 0, 0);
    want = saved;
    checkWrites("gaps");
    chk("gaps_n", 16'(want.size()), 16'd4);
    pins("gaps", 1, 0, 0, 8'd4);

    wrLog.delete();
    s = '{8'h05, 8'h01, 8'h02};
    load(s, 0);
    tick(0, 1, 8'h03, 1);
    pins("midrst", 0, 0, 1, 8'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_wr", 16'(ext_mem_write), 16'd0);
    chk("midrst_adr", 16'(ext_data_adr), 16'd0);
    repeat (3) tick(0, 1, 8'h04, 0);
    want = '{16'h0001, 16'h0102};
    checkWrites("midrst");
    s = '{8'h01, 8'h05, 8'h05};
    load(s, 0);
    tick(0, 0, 0, 0);
    pins("reload", 1, 0, 0, 8'd1);
    chk("reload_last", {ext_data_adr, ext_write_data}, 16'h0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
